// File: rtl/dmem_if.sv
// Load/store request and response channels between the access stage
// (master) and a data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with a programmable number of wait states.
// One request is in flight at a time: IDLE accepts, WAIT burns the wait
// states, RESP holds the response until the consumer takes it.
// Stores commit and loads read the array on the edge that enters RESP.
// Optional build macro DMEM_RESP_MISALIGN_CHK_EN: misaligned half/word
// accesses fault instead of being silently aligned down.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2   // 0..15; the wait counter is 4 bits wide
) (
  input  logic  clk,
  input  logic  rst,              // asynchronous, active-low
  dmem_if.slave bus
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_unsigned;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_unsigned;

  logic             cur_fault;
  logic [1:0]       cur_off;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      rd_word;
  logic [31:0]      load_value;
  logic [3:0]       wr_be;
  logic [31:0]      wr_lanes;
  logic             accept;
  logic             enter_resp;
  logic             commit;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    return uns ? {24'd0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    return uns ? {16'd0, h} : {{16{h[15]}}, h};
  endfunction

  // Offending low bits of half/word addresses are dropped; with the
  // misalign check enabled those accesses fault before this matters.
  function automatic logic [1:0] eff_offset(input logic [1:0] off, input logic [1:0] size);
    logic [1:0] r;
    case (size)
      2'b00:   r = off;
      2'b01:   r = {off[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size);
    logic f;
    f = (size == 2'b11) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
`ifdef DMEM_RESP_MISALIGN_CHK_EN
    if ((size == 2'b01) && addr[0])
      f = 1'b1;
    if ((size == 2'b10) && (addr[1:0] != 2'b00))
      f = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating the right-aligned store data puts it on every lane; the
  // byte enables then pick the lane(s) that actually change.
  function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] lane_read(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] r;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r = ext_byte(word[7:0], uns);
          2'b01:   r = ext_byte(word[15:8], uns);
          2'b10:   r = ext_byte(word[23:16], uns);
          default: r = ext_byte(word[31:24], uns);
        endcase
      end
      2'b01:   r = off[1] ? ext_half(word[31:16], uns) : ext_half(word[15:0], uns);
      default: r = word;
    endcase
    return r;
  endfunction

  // With zero wait states the response is formed on the accept edge itself,
  // so the live bus stands in for the not-yet-latched request while in IDLE.
  always_comb begin
    cur_we       = lat_we;
    cur_addr     = lat_addr;
    cur_wdata    = lat_wdata;
    cur_size     = lat_size;
    cur_unsigned = lat_unsigned;
    if (state == IDLE) begin
      cur_we       = bus.req_we;
      cur_addr     = bus.req_addr;
      cur_wdata    = bus.req_wdata;
      cur_size     = bus.req_size;
      cur_unsigned = bus.req_unsigned;
    end
  end

  assign cur_fault  = access_fault(cur_addr, cur_size);
  assign cur_off    = eff_offset(cur_addr[1:0], cur_size);
  assign cur_idx    = cur_addr[IDX_W+1:2];
  assign rd_word    = mem[cur_idx];
  assign wr_be      = lane_enable(cur_off, cur_size);
  assign wr_lanes   = lane_data(cur_wdata, cur_size);
  assign load_value = (cur_we || cur_fault) ? 32'd0
                                            : lane_read(rd_word, cur_off, cur_size, cur_unsigned);

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));
  // Gating with rst keeps a request presented during reset from writing.
  assign commit     = rst && enter_resp && cur_we && !cur_fault;

  // Request capture on accept; payload only, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we       <= bus.req_we;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
      lat_size     <= bus.req_size;
      lat_unsigned <= bus.req_unsigned;
    end
  end

  // Byte-enabled store commit on the edge that enters RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i])
          mem[cur_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        rsp_valid_r <= 1'b1;
        rsp_rdata_r <= load_value;
        rsp_err_r   <= cur_fault;
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven with directed
// and random traffic and checked through a scoreboard fed by a byte-level
// memory model, plus a WAIT_CYCLES=0 instance for back-to-back timing.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();
  dmem_if bus0();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WC)) dut  (.clk(clk), .rst(rst), .bus(bus));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0))  dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    string       tag;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [0:1023];
  logic       stall = 1'b0;
  logic       rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Byte-addressed little-endian memory; accesses are aligned down to their size.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic err, output logic [31:0] rdata);
    int     nb;
    int     base;
    longint v;
    err = (size == 2'd3) || ((addr / 4) >= 256);
`ifdef DMEM_RESP_MISALIGN_CHK_EN
    if ((size == 2'd1) && (addr % 2 != 0)) err = 1'b1;
    if ((size == 2'd2) && (addr % 4 != 0)) err = 1'b1;
`endif
    rdata = 32'd0;
    if (err) return;
    nb   = 1 << size;
    base = int'(addr) - (int'(addr) % nb);
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[base + i]) << (8 * i));
      if (!uns && (nb < 4) && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
      rdata = v[31:0];
    end
  endfunction

  // Consumer side: random or forced backpressure, changed just after each edge.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: every cycle a response is shown it must match the queue head.
  initial begin
    logic first_seen;
    logic expect_idle;
    first_seen  = 1'b0;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        first_seen  = 1'b0;
        expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          chk("idle_after_rsp_req_ready", 32'(bus.req_ready), 32'd1);
          expect_idle = 1'b0;
        end
        if (bus.rsp_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with rdata 0x%08h, required no response", bus.rsp_rdata);
          end else begin
            if (!first_seen) begin
              chk({sbq[0].tag, "_latency"}, 32'(cyc - sbq[0].acc), 32'(WC));
              first_seen = 1'b1;
            end
            chk({sbq[0].tag, "_rdata"}, bus.rsp_rdata, sbq[0].rdata);
            chk({sbq[0].tag, "_err"}, 32'(bus.rsp_err), 32'(sbq[0].err));
            chk({sbq[0].tag, "_req_ready_in_resp"}, 32'(bus.req_ready), 32'd0);
            if (bus.rsp_ready) begin
              void'(sbq.pop_front());
              first_seen  = 1'b0;
              expect_idle = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request, wait for the accept edge, then push its expectation.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input string tag, input bit scored);
    exp_t e;
    int   n;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: req_ready=0 for %0d cycles, required 1", tag, n);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (scored) begin
      model(we, addr, wdata, size, uns, e.err, e.rdata);
      e.acc = cyc;
      e.tag = tag;
      sbq.push_back(e);
    end
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d responses pending after %0d cycles, required 0", name, sbq.size(), n);
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w0_data [4];
    int          prev_acc;
    int          n;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    int          r;

    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_addr      = 32'd0;
    bus.req_wdata     = 32'd0;
    bus.req_size      = 2'd0;
    bus.req_unsigned  = 1'b0;
    bus0.req_valid    = 1'b0;
    bus0.req_we       = 1'b0;
    bus0.req_addr     = 32'd0;
    bus0.req_wdata    = 32'd0;
    bus0.req_size     = 2'd0;
    bus0.req_unsigned = 1'b0;
    bus0.rsp_ready    = 1'b1;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    gap(1);

    // Known contents for the first 32 words used by all later loads.
    for (int i = 0; i < 32; i++) issue(1'b1, 32'(4 * i), $urandom, 2'd2, 1'b0, "fill", 1'b1);
    drain("fill");

    // Reset in the middle of a store's wait states drops the store.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, "rst_abort", 1'b0);
    gap(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("postreset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("postreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    gap(1);
    issue(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, "rst_load_prior", 1'b1);

    issue(1'b1, 32'h20, 32'h12345678, 2'd2, 1'b0, "word_st", 1'b1);
    issue(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, "word_ld", 1'b1);

    issue(1'b1, 32'h21, 32'h00000080, 2'd0, 1'b0, "byte_st", 1'b1);
    issue(1'b0, 32'h21, 32'd0, 2'd0, 1'b0, "byte_ld_signed", 1'b1);
    issue(1'b0, 32'h21, 32'd0, 2'd0, 1'b1, "byte_ld_unsigned", 1'b1);
    issue(1'b0, 32'h20, 32'd0, 2'd2, 1'b1, "word_after_byte", 1'b1);
    issue(1'b0, 32'h22, 32'd0, 2'd1, 1'b0, "half_ld_hi", 1'b1);
    drain("directed");

    // Backpressure: response must hold while the consumer stalls.
    stall = 1'b1;
    issue(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, "bp_ld", 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    stall = 1'b0;
    drain("bp");

    issue(1'b0, 32'h400, 32'd0, 2'd2, 1'b0, "err_range", 1'b1);
    issue(1'b0, 32'h0, 32'd0, 2'd3, 1'b0, "err_size_ld", 1'b1);
    issue(1'b1, 32'h4, 32'hFFFFFFFF, 2'd3, 1'b0, "err_size_st", 1'b1);
    issue(1'b0, 32'h4, 32'd0, 2'd2, 1'b0, "err_size_nowrite", 1'b1);
    issue(1'b1, 32'h22, 32'hAABBCCDD, 2'd2, 1'b0, "misalign_st", 1'b1);
    issue(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, "misalign_check", 1'b1);
    drain("err");

    // Random traffic with random consumer backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int k = 0; k < 250; k++) begin
      r_we = 1'($urandom);
      r    = $urandom_range(0, 15);
      r_size = (r == 0) ? 2'd3 : 2'(r % 3);
      r = $urandom_range(0, 9);
      if (r == 0)      r_addr = 32'h400 + 32'($urandom_range(0, 4095));
      else if (r == 1) r_addr = {1'b1, 31'($urandom)};
      else             r_addr = 32'($urandom_range(0, 127));
      issue(r_we, r_addr, $urandom, r_size, 1'($urandom), "rand", 1'b1);
      gap($urandom_range(0, 2));
    end
    drain("rand");
    rand_ready = 1'b0;

    // Zero-wait instance: back-to-back store/load pairs, accepts every 2 cycles.
    for (int i = 0; i < 4; i++) w0_data[i] = $urandom;
    prev_acc = 0;
    bus0.req_valid    = 1'b1;
    bus0.req_we       = 1'b1;
    bus0.req_addr     = 32'h40;
    bus0.req_wdata    = w0_data[0];
    bus0.req_size     = 2'd2;
    bus0.req_unsigned = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      @(negedge clk);
      while (!bus0.req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus0.req_ready) begin
        checks++;
        errors++;
        $display("FAIL w0_accept: req_ready=0 for %0d cycles, required 1", n);
        break;
      end
      @(posedge clk);
      #1;
      if (k > 0) chk("w0_accept_spacing", 32'(cyc - prev_acc), 32'd2);
      prev_acc = cyc;
      if (k < 7) begin
        bus0.req_we    = ((k + 1) % 2 == 0);
        bus0.req_addr  = 32'h40 + 32'(4 * ((k + 1) / 2));
        bus0.req_wdata = w0_data[(k + 1) / 2];
      end else begin
        bus0.req_valid = 1'b0;
      end
      @(negedge clk);
      chk("w0_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("w0_rsp_err", 32'(bus0.rsp_err), 32'd0);
      chk("w0_rsp_rdata", bus0.rsp_rdata, (k % 2 == 0) ? 32'd0 : w0_data[k / 2]);
    end
    bus0.req_valid = 1'b0;
    gap(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
